ofdm_frame_sched: RTL and testbench

- Frame/symbol timing controller downstream of the SOP sync filter in the Rx chain.
- On a confirmed frame SOP it applies the reported SOP delay and walks each frame's N_SYMB symbols.
- For each symbol it skips the cyclic prefix and gates the FFTSIZE body samples into the FFT with sop/eop framing.
- It flywheels through missed SOPs for a bounded number of frames, then drops to idle.

---
 rtl/ofdm_frame_sched_pkg.sv | 29 ++
 rtl/ofdm_frame_sched_if.sv | 23 ++
 rtl/ofdm_frame_sched_sym_counter.sv | 27 ++
 rtl/ofdm_frame_sched.sv | 253 +++++++++++++++++++++++++
 tb/tb_ofdm_frame_sched.sv | 261 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/ofdm_frame_sched_pkg.sv
// Shared types and constants for the OFDM frame/symbol scheduler.
// Holds the FSM state encoding, default geometry and the SOP-delay clamp.
package rx_sched_pkg;

  localparam int N_SYMB_DEF      = 50;
  localparam int FFTSIZE_DEF     = 1024;
  localparam int CPSIZE_DEF      = 32;
  localparam int SOP_TIMEOUT_DEF = 64;
  localparam int MAX_FLY_DEF     = 2;

  localparam int N_SPFR    = FFTSIZE_DEF + CPSIZE_DEF;
  localparam int MAX_DELAY = 31;
  localparam int OFF_W     = $clog2(MAX_DELAY + 1);

  typedef enum logic [2:0] {
    IDLE,
    ALIGN,
    CP,
    BODY,
    WAIT_SOP
  } sched_state_e;

  // A 6-bit signed offset can never exceed MAX_DELAY, so only negatives need clamping.
  function automatic logic [OFF_W-1:0] clamp_delay(input logic signed [5:0] d);
    if (d[5]) return '0;
    else      return d[OFF_W-1:0];
  endfunction

endpackage

// File: rtl/ofdm_frame_sched_if.sv
// Sample-stream and FFT-handshake bundle between the sync filter, the scheduler and the FFT.
interface ofdm_frame_sched_if;

  logic              in_valid;
  logic              isop;
  logic              found_sync;
  logic signed [5:0] delay_sop;
  logic              fft_ready;
  logic              fft_valid;
  logic              fft_sop;
  logic              fft_eop;

  modport master (
    output in_valid, isop, found_sync, delay_sop, fft_ready,
    input  fft_valid, fft_sop, fft_eop
  );

  modport slave (
    input  in_valid, isop, found_sync, delay_sop, fft_ready,
    output fft_valid, fft_sop, fft_eop
  );

endinterface

// File: rtl/ofdm_frame_sched_sym_counter.sv
// Sample counter advancing on valid samples, with synchronous load and a terminal-count flag.
module sym_counter #(
  parameter int W    = 4,
  parameter int LAST = 15
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] cnt,
  output logic         tc
);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (en) begin
      if (load) cnt <= load_val;
      else      cnt <= cnt + 1'b1;
    end
  end

  assign tc = (cnt == W'(LAST));

endmodule

// File: rtl/ofdm_frame_sched.sv
// Rx frame/symbol timing controller: aligns to SOP, skips CP, gates FFT bodies, flywheels missed SOPs.
// Optional statistics counters are built when FRAME_SCHED_STATS_EN is defined.
module ofdm_frame_sched
  import rx_sched_pkg::*;
#(
  parameter int N_SYMB      = N_SYMB_DEF,
  parameter int FFTSIZE     = FFTSIZE_DEF,
  parameter int CPSIZE      = CPSIZE_DEF,
  parameter int SOP_TIMEOUT = SOP_TIMEOUT_DEF,
  parameter int MAX_FLY     = MAX_FLY_DEF,
  localparam int SYM_W      = $clog2(N_SYMB)
) (
  input  logic             clk,
  input  logic             rst,
  ofdm_frame_sched_if.slave sif,
  output logic [SYM_W-1:0] symb_idx,
  output logic             frame_start,
  output logic             frame_active,
  output logic             err_skip,
  output logic             sync_lost
`ifdef FRAME_SCHED_STATS_EN
  ,
  output logic [15:0]      frame_cnt,
  output logic [15:0]      skip_cnt,
  output logic [7:0]       fly_total
`endif
);

  localparam int CP_W  = $clog2(CPSIZE);
  localparam int FFT_W = $clog2(FFTSIZE);
  localparam int TO_W  = $clog2(SOP_TIMEOUT);
  localparam int FLY_W = $clog2(MAX_FLY + 1);

  localparam logic [SYM_W-1:0] LAST_SYM = SYM_W'(N_SYMB - 1);
  localparam logic [FLY_W-1:0] FLY_LIM  = FLY_W'(MAX_FLY);

  sched_state_e     state, state_nxt;
  logic [OFF_W-1:0] off_cnt, off_nxt;
  logic [SYM_W-1:0] symb_nxt;
  logic [FLY_W-1:0] fly_cnt, fly_nxt;
  logic             take_sym, take_nxt;
  logic             fft_valid_d, fft_sop_d, fft_eop_d;
  logic             frame_start_d, frame_active_d, err_skip_d, sync_lost_d;
  logic             sop_ok;

  logic [CP_W-1:0]  cp_cnt, cp_load_val;
  logic [FFT_W-1:0] body_cnt;
  logic [TO_W-1:0]  to_cnt;
  logic             cp_last, body_last, to_last;
  logic             body_first;

  assign sop_ok     = sif.isop & sif.found_sync;
  assign body_first = (body_cnt == '0);

  // The sample that ends ALIGN or WAIT_SOP is itself CP sample 0, so CP resumes counting at 1.
  assign cp_load_val = ((state_nxt == CP) && (state != BODY)) ? CP_W'(1) : '0;

  sym_counter #(.W(CP_W), .LAST(CPSIZE - 1)) u_cp_cnt (
    .clk      (clk),
    .rst      (rst),
    .en       (sif.in_valid),
    .load     ((state != CP) || (state_nxt != CP)),
    .load_val (cp_load_val),
    .cnt      (cp_cnt),
    .tc       (cp_last)
  );

  sym_counter #(.W(FFT_W), .LAST(FFTSIZE - 1)) u_body_cnt (
    .clk      (clk),
    .rst      (rst),
    .en       (sif.in_valid),
    .load     ((state != BODY) || (state_nxt != BODY)),
    .load_val ('0),
    .cnt      (body_cnt),
    .tc       (body_last)
  );

  sym_counter #(.W(TO_W), .LAST(SOP_TIMEOUT - 1)) u_to_cnt (
    .clk      (clk),
    .rst      (rst),
    .en       (sif.in_valid),
    .load     ((state != WAIT_SOP) || (state_nxt != WAIT_SOP)),
    .load_val ('0),
    .cnt      (to_cnt),
    .tc       (to_last)
  );

  // NOTE: every signal written here gets a default first so no path can infer a latch.
  always_comb begin
    state_nxt      = state;
    off_nxt        = off_cnt;
    symb_nxt       = symb_idx;
    fly_nxt        = fly_cnt;
    take_nxt       = take_sym;
    fft_valid_d    = 1'b0;
    fft_sop_d      = 1'b0;
    fft_eop_d      = 1'b0;
    frame_start_d  = 1'b0;
    frame_active_d = frame_active;
    err_skip_d     = 1'b0;
    sync_lost_d    = 1'b0;

    if (state == IDLE) begin
      frame_active_d = 1'b0;
      symb_nxt       = '0;
    end

    if (sif.in_valid) begin
      case (state)
        IDLE: begin
          if (sop_ok) begin
            state_nxt = ALIGN;
            off_nxt   = clamp_delay(sif.delay_sop);
            fly_nxt   = '0;
          end
        end

        ALIGN: begin
          frame_active_d = 1'b0;
          if (!sif.found_sync) begin
            state_nxt   = IDLE;
            sync_lost_d = 1'b1;
          end else if (sop_ok) begin
            off_nxt = clamp_delay(sif.delay_sop);
            fly_nxt = '0;
          end else if (off_cnt == '0) begin
            state_nxt      = CP;
            symb_nxt       = '0;
            frame_start_d  = 1'b1;
            frame_active_d = 1'b1;
          end else begin
            off_nxt = off_cnt - 1'b1;
          end
        end

        CP: begin
          frame_active_d = 1'b1;
          if (!sif.found_sync) begin
            state_nxt   = IDLE;
            sync_lost_d = 1'b1;
          end else if (sop_ok) begin
            state_nxt = ALIGN;
            off_nxt   = clamp_delay(sif.delay_sop);
            fly_nxt   = '0;
          end else if (cp_last) begin
            take_nxt  = sif.fft_ready;
            state_nxt = BODY;
          end
        end

        BODY: begin
          frame_active_d = 1'b1;
          fft_valid_d    = take_sym;
          fft_sop_d      = take_sym & body_first;
          fft_eop_d      = take_sym & body_last;
          err_skip_d     = ~take_sym & body_first;
          // Any early exit closes an open FFT frame with a forced eop.
          if (!sif.found_sync) begin
            state_nxt   = IDLE;
            sync_lost_d = 1'b1;
            fft_eop_d   = take_sym;
          end else if (sop_ok) begin
            state_nxt = ALIGN;
            off_nxt   = clamp_delay(sif.delay_sop);
            fly_nxt   = '0;
            fft_eop_d = take_sym;
          end else if (body_last) begin
            if (symb_idx < LAST_SYM) begin
              symb_nxt  = symb_idx + 1'b1;
              state_nxt = CP;
            end else begin
              state_nxt = WAIT_SOP;
            end
          end
        end

        WAIT_SOP: begin
          frame_active_d = 1'b0;
          if (!sif.found_sync) begin
            state_nxt   = IDLE;
            sync_lost_d = 1'b1;
          end else if (sop_ok) begin
            state_nxt = ALIGN;
            off_nxt   = clamp_delay(sif.delay_sop);
            fly_nxt   = '0;
          end else if (to_last) begin
            if (fly_cnt < FLY_LIM) begin
              fly_nxt        = fly_cnt + 1'b1;
              state_nxt      = CP;
              symb_nxt       = '0;
              frame_start_d  = 1'b1;
              frame_active_d = 1'b1;
            end else begin
              state_nxt   = IDLE;
              sync_lost_d = 1'b1;
            end
          end
        end

        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      off_cnt       <= '0;
      symb_idx      <= '0;
      fly_cnt       <= '0;
      take_sym      <= 1'b0;
      sif.fft_valid <= 1'b0;
      sif.fft_sop   <= 1'b0;
      sif.fft_eop   <= 1'b0;
      frame_start   <= 1'b0;
      frame_active  <= 1'b0;
      err_skip      <= 1'b0;
      sync_lost     <= 1'b0;
    end else begin
      state         <= state_nxt;
      off_cnt       <= off_nxt;
      symb_idx      <= symb_nxt;
      fly_cnt       <= fly_nxt;
      take_sym      <= take_nxt;
      sif.fft_valid <= fft_valid_d;
      sif.fft_sop   <= fft_sop_d;
      sif.fft_eop   <= fft_eop_d;
      frame_start   <= frame_start_d;
      frame_active  <= frame_active_d;
      err_skip      <= err_skip_d;
      sync_lost     <= sync_lost_d;
    end
  end

`ifdef FRAME_SCHED_STATS_EN
  logic fly_evt;
  assign fly_evt = sif.in_valid && (state == WAIT_SOP) && (state_nxt == CP);

  // Saturating event counters; only rst clears them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_cnt <= '0;
      skip_cnt  <= '0;
      fly_total <= '0;
    end else begin
      if (frame_start_d && (frame_cnt != '1)) frame_cnt <= frame_cnt + 1'b1;
      if (err_skip_d && (skip_cnt != '1))     skip_cnt  <= skip_cnt + 1'b1;
      if (fly_evt && (fly_total != '1))       fly_total <= fly_total + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_ofdm_frame_sched.sv
// Directed bench for ofdm_frame_sched with a small geometry (16-sample body, 4-sample CP, 3 symbols).
module tb_ofdm_frame_sched;

  localparam int N_SYMB      = 3;
  localparam int FFTSIZE     = 16;
  localparam int CPSIZE      = 4;
  localparam int SOP_TIMEOUT = 8;
  localparam int MAX_FLY     = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] symb_idx;
  logic       frame_start, frame_active, err_skip, sync_lost;
`ifdef FRAME_SCHED_STATS_EN
  logic [15:0] frame_cnt, skip_cnt;
  logic [7:0]  fly_total;
`endif

  ofdm_frame_sched_if ifc ();

  ofdm_frame_sched #(
    .N_SYMB      (N_SYMB),
    .FFTSIZE     (FFTSIZE),
    .CPSIZE      (CPSIZE),
    .SOP_TIMEOUT (SOP_TIMEOUT),
    .MAX_FLY     (MAX_FLY)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .sif          (ifc),
    .symb_idx     (symb_idx),
    .frame_start  (frame_start),
    .frame_active (frame_active),
    .err_skip     (err_skip),
    .sync_lost    (sync_lost)
`ifdef FRAME_SCHED_STATS_EN
    ,
    .frame_cnt    (frame_cnt),
    .skip_cnt     (skip_cnt),
    .fly_total    (fly_total)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Event log, timestamps in valid samples relative to the last clear_log().
  int vcyc = 0;
  int base = 0;
  int fs_n, sop_n, eop_n, val_n, skip_n, sl_n;
  int fs_t[16];
  int sop_t[16];
  int sop_sym[16];
  int eop_t[16];
  int skip_t[16];
  int sl_t[16];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic clear_log();
    base   = vcyc;
    fs_n   = 0;
    sop_n  = 0;
    eop_n  = 0;
    val_n  = 0;
    skip_n = 0;
    sl_n   = 0;
  endtask

  task automatic tick();
    logic iv;
    int   rel;
    iv = ifc.in_valid;
    @(posedge clk);
    #1;
    if (iv) vcyc++;
    rel = vcyc - base;
    if (frame_start) begin if (fs_n < 16) fs_t[fs_n] = rel; fs_n++; end
    if (ifc.fft_sop) begin
      if (sop_n < 16) begin sop_t[sop_n] = rel; sop_sym[sop_n] = int'(symb_idx); end
      sop_n++;
    end
    if (ifc.fft_eop) begin if (eop_n < 16) eop_t[eop_n] = rel; eop_n++; end
    if (ifc.fft_valid) val_n++;
    if (err_skip) begin if (skip_n < 16) skip_t[skip_n] = rel; skip_n++; end
    if (sync_lost) begin if (sl_n < 16) sl_t[sl_n] = rel; sl_n++; end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    ifc.in_valid   = 1'b0;
    ifc.isop       = 1'b0;
    ifc.found_sync = 1'b0;
    ifc.delay_sop  = 6'sd0;
    ifc.fft_ready  = 1'b1;
    rst = 1'b0;
    clear_log();
    #1 rst = 1'b1;
    #2;
    check("reset fft_valid", ifc.fft_valid, 0);
    check("reset frame_active", frame_active, 0);
    check("reset symb_idx", symb_idx, 0);
    check("reset sync_lost", sync_lost, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Basic frame with delay 2, then two flywheel frames and loss of sync.
    ifc.in_valid   = 1'b1;
    ifc.found_sync = 1'b1;
    ticks(2);
    ifc.isop      = 1'b1;
    ifc.delay_sop = 6'sd2;
    tick();
    clear_log();
    ifc.isop = 1'b0;
    ticks(210);
    check("basic frame_start time", fs_t[0], 3);
    check("basic first sop time", sop_t[0], 7);
    check("basic sop1 time", sop_t[1], 27);
    check("basic sop2 time", sop_t[2], 47);
    check("basic eop0 time", eop_t[0], 22);
    check("basic eop2 time", eop_t[2], 62);
    check("basic symb at sop0", sop_sym[0], 0);
    check("basic symb at sop1", sop_sym[1], 1);
    check("basic symb at sop2", sop_sym[2], 2);
    check("fly frame1 start", fs_t[1], 70);
    check("fly frame2 start", fs_t[2], 137);
    check("fly frame1 sop", sop_t[3], 74);
    check("fly total frames", fs_n, 3);
    check("fly valid samples", val_n, 144);
    check("fly sync_lost count", sl_n, 1);
    check("fly sync_lost time", sl_t[0], 204);
    check("fly err_skip count", skip_n, 0);
    check("fly idle frame_active", frame_active, 0);

    // Negative delay clamps to 0, then sync loss at body sample 5.
    ifc.isop      = 1'b1;
    ifc.delay_sop = -6'sd5;
    tick();
    clear_log();
    ifc.isop = 1'b0;
    ticks(9);
    ifc.found_sync = 1'b0;
    tick();
    check("neg frame_start time", fs_t[0], 1);
    check("neg first sop time", sop_t[0], 5);
    check("loss fft_valid", ifc.fft_valid, 1);
    check("loss forced eop", ifc.fft_eop, 1);
    check("loss fft_sop", ifc.fft_sop, 0);
    check("loss sync_lost", sync_lost, 1);
    tick();
    check("post-loss fft_valid", ifc.fft_valid, 0);
    check("post-loss fft_eop", ifc.fft_eop, 0);
    check("post-loss sync_lost", sync_lost, 0);
    check("post-loss frame_active", frame_active, 0);
    check("post-loss symb_idx", symb_idx, 0);

    // isop without found_sync must be ignored.
    clear_log();
    ifc.isop      = 1'b1;
    ifc.delay_sop = 6'sd0;
    ticks(3);
    ifc.isop       = 1'b0;
    ifc.found_sync = 1'b1;
    ticks(5);
    check("ignored isop frame_start", fs_n, 0);
    check("ignored isop frame_active", frame_active, 0);

    // Backpressure on symbol 1, mid-body ready drop on symbol 2, isop on the last sample.
    ifc.isop = 1'b1;
    tick();
    clear_log();
    ifc.isop = 1'b0;
    ticks(23);
    ifc.fft_ready = 1'b0;
    tick();
    ifc.fft_ready = 1'b1;
    ticks(25);
    ifc.fft_ready = 1'b0;
    tick();
    ifc.fft_ready = 1'b1;
    ticks(9);
    ifc.isop      = 1'b1;
    ifc.delay_sop = 6'sd1;
    tick();
    ifc.isop = 1'b0;
    check("bp frame_start time", fs_t[0], 1);
    check("bp err_skip count", skip_n, 1);
    check("bp err_skip time", skip_t[0], 25);
    check("bp valid samples", val_n, 32);
    check("bp sop count", sop_n, 2);
    check("bp sym2 sop time", sop_t[1], 45);
    check("bp sym2 eop time", eop_t[1], 60);

    // isop on the last frame sample wins: realign with delay 1, then re-SOP mid-body.
    clear_log();
    ticks(8);
    ifc.isop      = 1'b1;
    ifc.delay_sop = 6'sd0;
    tick();
    ifc.isop = 1'b0;
    check("last-sample isop frame_start", fs_t[0], 2);
    check("last-sample isop sop time", sop_t[0], 6);
    check("resop fft_valid", ifc.fft_valid, 1);
    check("resop forced eop", ifc.fft_eop, 1);
    check("resop eop count", eop_n, 1);
    clear_log();
    ticks(27);
    check("resop frame_start time", fs_t[0], 1);
    check("midframe fft_valid", ifc.fft_valid, 1);
    check("midframe symb_idx", symb_idx, 1);

    // Asynchronous reset mid-body clears everything without a clock edge.
    #3 rst = 1'b1;
    #1;
    check("async rst fft_valid", ifc.fft_valid, 0);
    check("async rst frame_active", frame_active, 0);
    check("async rst symb_idx", symb_idx, 0);
    @(negedge clk);
    rst = 1'b0;

    // Gapped input: timing in valid samples must match the basic frame.
    ifc.isop      = 1'b1;
    ifc.delay_sop = 6'sd2;
    tick();
    clear_log();
    ifc.isop = 1'b0;
    for (int i = 1; i <= 130; i++) begin
      ifc.in_valid = (i % 2 == 0);
      tick();
    end
    ifc.in_valid = 1'b1;
    check("gap frame_start time", fs_t[0], 3);
    check("gap sop0 time", sop_t[0], 7);
    check("gap sop1 time", sop_t[1], 27);
    check("gap sop2 time", sop_t[2], 47);
    check("gap eop2 time", eop_t[2], 62);
    check("gap valid samples", val_n, 48);
`ifdef FRAME_SCHED_STATS_EN
    check("stats frame_cnt", frame_cnt, 1);
    check("stats skip_cnt", skip_cnt, 0);
    check("stats fly_total", fly_total, 0);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
